fir_stream_sequencer: RTL and testbench

Streaming front-end and sequencer for the block FIR filter. It accepts one signed 16-bit sample per handshake and packs `SAMPLES_NUM` samples into a block. It launches the filter with a single-cycle start pulse, holds the filter's input stable until completion, then captures the packed 32-bit results and serialises them one per handshake. It sits between the audio sample stream and the filter core, and is the only driver of the filter's `startIn`/`dataIn`.

---
 rtl/fir_pkg.sv | 18 +
 rtl/fir_result_serializer.sv | 79 +++++++
 rtl/fir_stream_sequencer.sv | 141 ++++++++++++++
 tb/tb_fir_stream_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the block FIR front-end.
//   IN_SAMPLE_WIDTH  : width of one raw input sample (signed).
//   OUT_SAMPLE_WIDTH : width of one filtered result from the filter core.
//   MAX_SAMPLES_NUM  : largest block size any instance may be built with.
//   seq_state_t      : sequencer FSM states.
package fir_pkg;

  localparam int unsigned IN_SAMPLE_WIDTH  = 16;
  localparam int unsigned OUT_SAMPLE_WIDTH = 32;
  localparam int unsigned MAX_SAMPLES_NUM  = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } seq_state_t;

endpackage

// File: rtl/fir_result_serializer.sv
// Result capture and valid/ready serialiser for the block FIR.
//   clkIn, nResetIn   : clock, asynchronous active-low reset.
//   captureIn         : load captureDataIn and start emitting from sample 0.
//   captureDataIn     : packed filter results, sample 0 in the MSB slice.
//   resultReadyIn     : downstream accepts resultOut.
//   resultOut         : current result (0 when not valid).
//   resultValidOut    : resultOut valid.
//   lastAcceptedOut   : single-cycle pulse when the final result is accepted.
module fir_result_serializer
  import fir_pkg::*;
#(
  parameter int unsigned SAMPLES_NUM = 4
) (
  input  logic                                  clkIn,
  input  logic                                  nResetIn,
  input  logic                                  captureIn,
  input  logic [OUT_SAMPLE_WIDTH*SAMPLES_NUM-1:0] captureDataIn,
  input  logic                                  resultReadyIn,
  output logic [OUT_SAMPLE_WIDTH-1:0]           resultOut,
  output logic                                  resultValidOut,
  output logic                                  lastAcceptedOut
);

  localparam int unsigned ResW = OUT_SAMPLE_WIDTH * SAMPLES_NUM;
  localparam int unsigned IdxW = $clog2(MAX_SAMPLES_NUM);

  logic [ResW-1:0] resultQ, resultD;
  logic [IdxW-1:0] idxQ, idxD;
  logic            validQ, validD;
  logic            accept;
  logic            lastAccept;

  assign accept     = validQ && resultReadyIn;
  assign lastAccept = accept && (idxQ == IdxW'(SAMPLES_NUM - 1));

  always_comb begin
    resultD = resultQ;
    idxD    = idxQ;
    validD  = validQ;
    if (captureIn) begin
      resultD = captureDataIn;
      idxD    = '0;
      validD  = 1'b1;
    end else if (lastAccept) begin
      idxD   = '0;
      validD = 1'b0;
    end else if (accept) begin
      idxD = idxQ + IdxW'(1);
    end
  end

  // Sample k lives in slice N-1-k, so the first result comes from the top.
  always_comb begin
    resultOut = '0;
    if (validQ) begin
      for (int unsigned i = 0; i < SAMPLES_NUM; i++) begin
        if (idxQ == IdxW'(i)) begin
          resultOut = resultQ[OUT_SAMPLE_WIDTH*(SAMPLES_NUM-1-i) +: OUT_SAMPLE_WIDTH];
        end
      end
    end
  end

  assign resultValidOut  = validQ;
  assign lastAcceptedOut = lastAccept;

  always_ff @(posedge clkIn or negedge nResetIn) begin
    if (!nResetIn) begin
      resultQ <= '0;
      idxQ    <= '0;
      validQ  <= 1'b0;
    end else begin
      resultQ <= resultD;
      idxQ    <= idxD;
      validQ  <= validD;
    end
  end

endmodule

// File: rtl/fir_stream_sequencer.sv
// Streaming front-end and sequencer for the block FIR filter.
// Packs SAMPLES_NUM input samples, launches the filter with a one-cycle start,
// holds the filter input until done, then serialises the packed results.
//   clkIn, nResetIn            : clock, asynchronous active-low reset.
//   sampleIn/ValidIn/ReadyOut  : input sample stream.
//   firStartOut, firDataOut    : filter launch pulse and held block input.
//   firBusyIn, firDoneIn       : filter status.
//   firDataIn                  : filter packed results.
//   resultOut/ValidOut/ReadyIn : output result stream.
//   errOut                     : sticky protocol error.
module fir_stream_sequencer
  import fir_pkg::*;
#(
  parameter int unsigned SAMPLES_NUM = 4
) (
  input  logic                                   clkIn,
  input  logic                                   nResetIn,
  input  logic [IN_SAMPLE_WIDTH-1:0]             sampleIn,
  input  logic                                   sampleValidIn,
  output logic                                   sampleReadyOut,
  output logic                                   firStartOut,
  input  logic                                   firBusyIn,
  input  logic                                   firDoneIn,
  output logic [IN_SAMPLE_WIDTH*SAMPLES_NUM-1:0]  firDataOut,
  input  logic [OUT_SAMPLE_WIDTH*SAMPLES_NUM-1:0] firDataIn,
  output logic [OUT_SAMPLE_WIDTH-1:0]            resultOut,
  output logic                                   resultValidOut,
  input  logic                                   resultReadyIn,
  output logic                                   errOut
);

  localparam int unsigned PackW = IN_SAMPLE_WIDTH * SAMPLES_NUM;
  localparam int unsigned CntW  = $clog2(MAX_SAMPLES_NUM + 1);

  seq_state_t       stateQ, stateD;
  logic [PackW-1:0] packQ, packD;
  logic [PackW-1:0] firDataQ, firDataD;
  logic [CntW-1:0]  packCountQ, packCountD;
  logic             firStartQ, firStartD;
  logic             errQ, errD;
  logic             packFull;
  logic             sampleAccept;
  logic             launch;
  logic             capture;
  logic             lastAccepted;

  assign packFull       = (packCountQ == CntW'(SAMPLES_NUM));
  assign sampleReadyOut = !packFull;
  assign sampleAccept   = sampleValidIn && !packFull;

  // Packing is free-running so the next block fills while this one runs.
  // Launch and acceptance are exclusive because launch requires a full pack.
  always_comb begin
    packD      = packQ;
    packCountD = packCountQ;
    if (sampleAccept) begin
      for (int unsigned i = 0; i < SAMPLES_NUM; i++) begin
        if (packCountQ == CntW'(i)) begin
          packD[IN_SAMPLE_WIDTH*i +: IN_SAMPLE_WIDTH] = sampleIn;
        end
      end
      packCountD = packCountQ + CntW'(1);
    end
    if (launch) begin
      packCountD = '0;
    end
  end

  always_comb begin
    stateD    = stateQ;
    firStartD = 1'b0;
    firDataD  = firDataQ;
    errD      = errQ;
    launch    = 1'b0;
    capture   = 1'b0;
    unique case (stateQ)
      IDLE: begin
        if (packFull && !firBusyIn) begin
          launch    = 1'b1;
          firStartD = 1'b1;
          firDataD  = packQ;
          stateD    = RUN;
        end
      end
      RUN: begin
        if (firDoneIn) begin
          capture = 1'b1;
          stateD  = DRAIN;
        end else if (!firStartQ && !firBusyIn) begin
          // firStartQ marks the first RUN cycle, before busy can respond.
          errD = 1'b1;
        end
      end
      DRAIN: begin
        if (lastAccepted) begin
          stateD = IDLE;
        end
      end
      default: stateD = IDLE;
    endcase
    if (firDoneIn && (stateQ != RUN)) begin
      errD = 1'b1;
    end
  end

  fir_result_serializer #(
    .SAMPLES_NUM(SAMPLES_NUM)
  ) uSerializer (
    .clkIn          (clkIn),
    .nResetIn       (nResetIn),
    .captureIn      (capture),
    .captureDataIn  (firDataIn),
    .resultReadyIn  (resultReadyIn),
    .resultOut      (resultOut),
    .resultValidOut (resultValidOut),
    .lastAcceptedOut(lastAccepted)
  );

  assign firStartOut = firStartQ;
  assign firDataOut  = firDataQ;
  assign errOut      = errQ;

  always_ff @(posedge clkIn or negedge nResetIn) begin
    if (!nResetIn) begin
      stateQ     <= IDLE;
      packQ      <= '0;
      packCountQ <= '0;
      firDataQ   <= '0;
      firStartQ  <= 1'b0;
      errQ       <= 1'b0;
    end else begin
      stateQ     <= stateD;
      packQ      <= packD;
      packCountQ <= packCountD;
      firDataQ   <= firDataD;
      firStartQ  <= firStartD;
      errQ       <= errD;
    end
  end

endmodule

// File: tb/tb_fir_stream_sequencer.sv
module tb_fir_stream_sequencer;

  logic clkIn;
  logic nResetIn;

  // N = 4 instance
  logic [15:0]  sampleIn4;
  logic         sampleValidIn4;
  logic         sampleReadyOut4;
  logic         firStartOut4;
  logic         firBusyIn4;
  logic         firDoneIn4;
  logic [63:0]  firDataOut4;
  logic [127:0] firDataIn4;
  logic [31:0]  resultOut4;
  logic         resultValidOut4;
  logic         resultReadyIn4;
  logic         errOut4;

  // N = 1 instance
  logic [15:0]  sampleIn1;
  logic         sampleValidIn1;
  logic         sampleReadyOut1;
  logic         firStartOut1;
  logic         firBusyIn1;
  logic         firDoneIn1;
  logic [15:0]  firDataOut1;
  logic [31:0]  firDataIn1;
  logic [31:0]  resultOut1;
  logic         resultValidOut1;
  logic         resultReadyIn1;
  logic         errOut1;

  int vectors;
  int miscompares;

  fir_stream_sequencer #(
    .SAMPLES_NUM(4)
  ) dut4 (
    .clkIn         (clkIn),
    .nResetIn      (nResetIn),
    .sampleIn      (sampleIn4),
    .sampleValidIn (sampleValidIn4),
    .sampleReadyOut(sampleReadyOut4),
    .firStartOut   (firStartOut4),
    .firBusyIn     (firBusyIn4),
    .firDoneIn     (firDoneIn4),
    .firDataOut    (firDataOut4),
    .firDataIn     (firDataIn4),
    .resultOut     (resultOut4),
    .resultValidOut(resultValidOut4),
    .resultReadyIn (resultReadyIn4),
    .errOut        (errOut4)
  );

  fir_stream_sequencer #(
    .SAMPLES_NUM(1)
  ) dut1 (
    .clkIn         (clkIn),
    .nResetIn      (nResetIn),
    .sampleIn      (sampleIn1),
    .sampleValidIn (sampleValidIn1),
    .sampleReadyOut(sampleReadyOut1),
    .firStartOut   (firStartOut1),
    .firBusyIn     (firBusyIn1),
    .firDoneIn     (firDoneIn1),
    .firDataOut    (firDataOut1),
    .firDataIn     (firDataIn1),
    .resultOut     (resultOut1),
    .resultValidOut(resultValidOut1),
    .resultReadyIn (resultReadyIn1),
    .errOut        (errOut1)
  );

  initial clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  task automatic tick();
    @(posedge clkIn);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    nResetIn       = 1'b0;
    sampleIn4      = '0;
    sampleValidIn4 = 1'b0;
    firBusyIn4     = 1'b0;
    firDoneIn4     = 1'b0;
    firDataIn4     = '0;
    resultReadyIn4 = 1'b0;
    sampleIn1      = '0;
    sampleValidIn1 = 1'b0;
    firBusyIn1     = 1'b0;
    firDoneIn1     = 1'b0;
    firDataIn1     = '0;
    resultReadyIn1 = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_start", 64'(firStartOut4), 64'd0);
    chk("rst_data", firDataOut4, 64'd0);
    chk("rst_result", 64'(resultOut4), 64'd0);
    chk("rst_valid", 64'(resultValidOut4), 64'd0);
    chk("rst_err", 64'(errOut4), 64'd0);
    chk("rst_ready", 64'(sampleReadyOut4), 64'd1);
    nResetIn = 1'b1;
    tick();

    // Block 1: samples 1..4 back-to-back
    sampleValidIn4 = 1'b1;
    sampleIn4 = 16'd1; tick();
    sampleIn4 = 16'd2; tick();
    sampleIn4 = 16'd3; tick();
    sampleIn4 = 16'd4; tick();
    sampleValidIn4 = 1'b0;
    chk("b1_full_ready", 64'(sampleReadyOut4), 64'd0);
    chk("b1_no_early_start", 64'(firStartOut4), 64'd0);
    tick();
    chk("b1_start", 64'(firStartOut4), 64'd1);
    chk("b1_data", firDataOut4, 64'h0004_0003_0002_0001);
    chk("b1_ready_after_launch", 64'(sampleReadyOut4), 64'd1);
    firBusyIn4 = 1'b1;

    // Block 2 fills during block 1 RUN
    sampleValidIn4 = 1'b1;
    sampleIn4 = 16'h0011; tick();
    chk("b1_start_one_cycle", 64'(firStartOut4), 64'd0);
    sampleIn4 = 16'h0022; tick();
    sampleIn4 = 16'h0033; tick();
    sampleIn4 = 16'h0044; tick();
    sampleValidIn4 = 1'b0;
    chk("b2_full_ready", 64'(sampleReadyOut4), 64'd0);
    chk("b1_data_held_run", firDataOut4, 64'h0004_0003_0002_0001);
    chk("b1_no_relaunch_run", 64'(firStartOut4), 64'd0);
    chk("b1_err_run", 64'(errOut4), 64'd0);

    // Filter completes block 1
    firDataIn4 = {32'hA, 32'hB, 32'hC, 32'hD};
    firDoneIn4 = 1'b1;
    firBusyIn4 = 1'b0;
    chk("b1_valid_before_done", 64'(resultValidOut4), 64'd0);
    tick();
    firDoneIn4 = 1'b0;
    chk("b1_valid_d1", 64'(resultValidOut4), 64'd1);
    chk("b1_r0", 64'(resultOut4), 64'hA);
    resultReadyIn4 = 1'b1; tick();
    chk("b1_r1", 64'(resultOut4), 64'hB);
    resultReadyIn4 = 1'b0; tick();
    chk("b1_r1_hold_a", 64'(resultOut4), 64'hB);
    chk("b1_valid_hold", 64'(resultValidOut4), 64'd1);
    tick();
    chk("b1_r1_hold_b", 64'(resultOut4), 64'hB);
    chk("b1_no_launch_drain", 64'(firStartOut4), 64'd0);
    resultReadyIn4 = 1'b1; tick();
    chk("b1_r2", 64'(resultOut4), 64'hC);
    chk("b1_data_held_drain", firDataOut4, 64'h0004_0003_0002_0001);
    tick();
    chk("b1_r3", 64'(resultOut4), 64'hD);
    chk("b1_r3_valid", 64'(resultValidOut4), 64'd1);
    firBusyIn4 = 1'b1; tick();
    // IDLE bubble with filter still busy: no launch
    chk("b1_valid_fall", 64'(resultValidOut4), 64'd0);
    chk("b2_wait_busy_start", 64'(firStartOut4), 64'd0);
    chk("b2_wait_busy_ready", 64'(sampleReadyOut4), 64'd0);
    tick();
    chk("b2_still_waiting", 64'(firStartOut4), 64'd0);
    firBusyIn4 = 1'b0; tick();
    chk("b2_start", 64'(firStartOut4), 64'd1);
    chk("b2_data", firDataOut4, 64'h0044_0033_0022_0011);
    chk("b2_ready", 64'(sampleReadyOut4), 64'd1);
    chk("b2_err", 64'(errOut4), 64'd0);

    // Block 2 run with one stray sample left in the pack
    firBusyIn4 = 1'b1;
    sampleValidIn4 = 1'b1;
    sampleIn4 = 16'h0099; tick();
    sampleValidIn4 = 1'b0;
    tick();
    firDataIn4 = {32'h1111_0000, 32'h2222_0000, 32'h3333_0000, 32'h4444_0000};
    firDoneIn4 = 1'b1;
    firBusyIn4 = 1'b0;
    tick();
    firDoneIn4 = 1'b0;
    resultReadyIn4 = 1'b1;
    chk("b2_r0", 64'(resultOut4), 64'h1111_0000);
    tick();
    chk("b2_r1", 64'(resultOut4), 64'h2222_0000);
    tick();
    chk("b2_r2_pre_reset", 64'(resultOut4), 64'h3333_0000);

    // Reset mid-DRAIN
    nResetIn = 1'b0;
    #1;
    chk("mid_rst_start", 64'(firStartOut4), 64'd0);
    chk("mid_rst_data", firDataOut4, 64'd0);
    chk("mid_rst_result", 64'(resultOut4), 64'd0);
    chk("mid_rst_valid", 64'(resultValidOut4), 64'd0);
    chk("mid_rst_err", 64'(errOut4), 64'd0);
    chk("mid_rst_ready", 64'(sampleReadyOut4), 64'd1);
    tick();
    nResetIn = 1'b1;
    resultReadyIn4 = 1'b0;
    tick();

    // Block 5..8 after reset
    sampleValidIn4 = 1'b1;
    sampleIn4 = 16'd5; tick();
    sampleIn4 = 16'd6; tick();
    sampleIn4 = 16'd7; tick();
    chk("b3_not_full", 64'(sampleReadyOut4), 64'd1);
    sampleIn4 = 16'd8; tick();
    sampleValidIn4 = 1'b0;
    tick();
    chk("b3_start", 64'(firStartOut4), 64'd1);
    chk("b3_data", firDataOut4, 64'h0008_0007_0006_0005);
    firBusyIn4 = 1'b1;
    tick();
    tick();
    firDataIn4 = {32'hFFFF_8000, 32'h0000_7FFF, 32'h0000_0001, 32'h8000_0000};
    firDoneIn4 = 1'b1;
    firBusyIn4 = 1'b0;
    resultReadyIn4 = 1'b1;
    tick();
    firDoneIn4 = 1'b0;
    chk("b3_r0", 64'(resultOut4), 64'hFFFF_8000);
    tick();
    chk("b3_r1", 64'(resultOut4), 64'h0000_7FFF);
    tick();
    chk("b3_r2", 64'(resultOut4), 64'h0000_0001);
    tick();
    chk("b3_r3", 64'(resultOut4), 64'h8000_0000);
    tick();
    chk("b3_valid_fall", 64'(resultValidOut4), 64'd0);
    chk("b3_err", 64'(errOut4), 64'd0);

    // Spurious done in IDLE
    firDoneIn4 = 1'b1;
    tick();
    firDoneIn4 = 1'b0;
    chk("spur_err_set", 64'(errOut4), 64'd1);
    chk("spur_no_result", 64'(resultValidOut4), 64'd0);
    chk("spur_no_start", 64'(firStartOut4), 64'd0);
    tick();
    tick();
    chk("spur_err_sticky", 64'(errOut4), 64'd1);
    chk("spur_no_result_late", 64'(resultValidOut4), 64'd0);
    sampleValidIn4 = 1'b1;
    sampleIn4 = 16'h00A1; tick();
    sampleIn4 = 16'h00A2; tick();
    sampleIn4 = 16'h00A3; tick();
    sampleIn4 = 16'h00A4; tick();
    sampleValidIn4 = 1'b0;
    tick();
    chk("spur_still_idle_launch", 64'(firStartOut4), 64'd1);
    chk("spur_launch_data", firDataOut4, 64'h00A4_00A3_00A2_00A1);

    // N = 1: every sample is a block
    sampleValidIn1 = 1'b1;
    sampleIn1 = 16'h1234; tick();
    sampleValidIn1 = 1'b0;
    chk("n1_full_ready", 64'(sampleReadyOut1), 64'd0);
    chk("n1_no_early_start", 64'(firStartOut1), 64'd0);
    tick();
    chk("n1_start", 64'(firStartOut1), 64'd1);
    chk("n1_data", 64'(firDataOut1), 64'h1234);
    chk("n1_ready", 64'(sampleReadyOut1), 64'd1);
    firBusyIn1 = 1'b1;
    tick();
    chk("n1_start_one_cycle", 64'(firStartOut1), 64'd0);
    firDataIn1 = 32'hDEAD_BEEF;
    firDoneIn1 = 1'b1;
    firBusyIn1 = 1'b0;
    tick();
    firDoneIn1 = 1'b0;
    chk("n1_valid", 64'(resultValidOut1), 64'd1);
    chk("n1_result", 64'(resultOut1), 64'hDEAD_BEEF);
    resultReadyIn1 = 1'b1;
    tick();
    chk("n1_valid_fall", 64'(resultValidOut1), 64'd0);
    chk("n1_err", 64'(errOut1), 64'd0);
    sampleValidIn1 = 1'b1;
    sampleIn1 = 16'hABCD; tick();
    sampleValidIn1 = 1'b0;
    tick();
    chk("n1_second_start", 64'(firStartOut1), 64'd1);
    chk("n1_second_data", 64'(firDataOut1), 64'hABCD);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
